dds_phase_gen: RTL and testbench

//  Numerically controlled oscillator front end for the 256-entry sine lookup ROM.
//  A divider produces sample ticks. On each tick the phase accumulator advances by a tuning word.
//  The block issues ROM reads, captures the returned sample, and presents it on a valid/ready

---
 rtl/dds_pkg.sv | 16 +
 rtl/dds_phase_gen_if.sv | 31 +++
 rtl/sample_fifo2.sv | 62 ++++++
 rtl/dds_phase_gen.sv | 114 +++++++++++
 tb/tb_dds_phase_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase generator: default widths and the
// phase-to-ROM-address mapping.
package dds_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned PHASE_W = 24;
  localparam int unsigned DIV_W   = 16;

  // Top ADDR_W phase bits plus offset, modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] phase_to_addr(input logic [PHASE_W-1:0] phase,
                                                      input logic [ADDR_W-1:0]  off);
    return phase[PHASE_W-1 -: ADDR_W] + off;
  endfunction

endpackage

// File: rtl/dds_phase_gen_if.sv
// ROM read port plus output sample stream of the DDS phase generator.
//  rom_rd/rom_addr  : read strobe and address toward the sine ROM
//  rom_data         : registered ROM d_out, valid the cycle after rom_rd
//  sample_*         : valid/ready sample stream toward the consumer
interface dds_phase_gen_if
  import dds_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned ADDR_WIDTH = ADDR_W
) ();

  logic                  rom_rd;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] sample_out;
  logic                  sample_valid;
  logic                  sample_ready;

  // Generator side
  modport master (
    output rom_rd, rom_addr, sample_out, sample_valid,
    input  rom_data, sample_ready
  );

  // ROM + consumer side
  modport slave (
    input  rom_rd, rom_addr, sample_out, sample_valid,
    output rom_data, sample_ready
  );

endinterface

// File: rtl/sample_fifo2.sv
// Two-entry sample FIFO. A push while full is accepted only if a pop happens
// in the same cycle; otherwise the caller treats it as a drop.
//  i_clr          : synchronous clear (empties the FIFO)
//  i_push/i_data  : write request and data
//  i_pop          : read request (ignored when empty)
//  o_full/o_empty : occupancy flags
//  o_head         : oldest entry
module sample_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// NCO front end for a sine ROM: divider ticks advance a phase accumulator,
// each tick issues a ROM read, the returned sample is captured one cycle
// later and queued in a 2-entry FIFO toward a valid/ready consumer.
//  clk, rst_n          : clock, async active-low reset
//  en, sync_clr        : divider enable, synchronous clear
//  ftw, phase_off, div : tuning word, address offset, tick period - 1
//  bus                 : ROM read port and sample stream
//  wrap                : pulse on accumulator carry-out
//  overrun, *_flag     : pulse / sticky indication of a dropped sample
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_W,
  parameter int unsigned ADDR_WIDTH  = ADDR_W,
  parameter int unsigned PHASE_WIDTH = PHASE_W,
  parameter int unsigned DIV_WIDTH   = DIV_W,
  parameter bit          SIGNED_OUT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sync_clr,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic [ADDR_WIDTH-1:0]  phase_off,
  input  logic [DIV_WIDTH-1:0]   div,
  dds_phase_gen_if.master        bus,
  output logic                   wrap,
  output logic                   overrun,
  output logic                   overrun_flag
);

  // Flips the sample MSB to turn offset-binary into two's complement.
  localparam logic [DATA_WIDTH-1:0] SIGN_MASK =
    DATA_WIDTH'(SIGNED_OUT) << (DATA_WIDTH - 1);

  logic [PHASE_WIDTH-1:0] r_phase;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic                   r_rom_rd;
  logic [ADDR_WIDTH-1:0]  r_rom_addr;
  logic                   r_s2_vld;
  logic                   r_wrap;
  logic                   r_overrun;
  logic                   r_overrun_flag;

  logic                   w_tick;
  logic [PHASE_WIDTH:0]   w_sum;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_WIDTH-1:0]  w_head;
  logic [DATA_WIDTH-1:0]  w_push_data;

  assign w_tick      = en & (r_cnt == '0);
  assign w_sum       = {1'b0, r_phase} + {1'b0, ftw};
  assign w_pop       = ~w_empty & bus.sample_ready;
  assign w_drop      = r_s2_vld & w_full & ~w_pop;
  assign w_push_data = bus.rom_data ^ SIGN_MASK;

  assign bus.rom_rd       = r_rom_rd;
  assign bus.rom_addr     = r_rom_addr;
  assign bus.sample_out   = w_head;
  assign bus.sample_valid = ~w_empty;
  assign wrap             = r_wrap;
  assign overrun          = r_overrun;
  assign overrun_flag     = r_overrun_flag;

  // Divider, accumulator, ROM request and capture-stage valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase        <= '0;
      r_cnt          <= '0;
      r_rom_rd       <= 1'b0;
      r_rom_addr     <= '0;
      r_s2_vld       <= 1'b0;
      r_wrap         <= 1'b0;
      r_overrun      <= 1'b0;
      r_overrun_flag <= 1'b0;
    end else if (sync_clr) begin
      r_phase        <= '0;
      r_cnt          <= '0;
      r_rom_rd       <= 1'b0;
      r_s2_vld       <= 1'b0;
      r_wrap         <= 1'b0;
      r_overrun      <= 1'b0;
      r_overrun_flag <= 1'b0;
    end else begin
      r_rom_rd  <= w_tick;
      r_wrap    <= w_tick & w_sum[PHASE_WIDTH];
      r_s2_vld  <= r_rom_rd;
      r_overrun <= w_drop;
      if (w_drop) r_overrun_flag <= 1'b1;
      if (en) r_cnt <= w_tick ? div : r_cnt - DIV_WIDTH'(1);
      if (w_tick) begin
        r_phase    <= w_sum[PHASE_WIDTH-1:0];
        r_rom_addr <= phase_to_addr(r_phase, phase_off);
      end
    end
  end

  // ROM data is consumed live in the capture cycle and pushed at its end.
  sample_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (sync_clr),
    .i_push  (r_s2_vld),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: two instances (offset-binary and signed output)
// share stimulus; each has its own registered ROM model.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync_clr;
  logic [23:0] ftw;
  logic [7:0]  phase_off;
  logic [15:0] div;
  logic        ready;
  logic        wrap0, overrun0, oflag0;
  logic        wrap1, overrun1, oflag1;
  logic [7:0]  rom_q0, rom_q1;
  logic [7:0]  rom_mem [256];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dds_phase_gen_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) if0 ();
  dds_phase_gen_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) if1 ();

  assign if0.rom_data     = rom_q0;
  assign if1.rom_data     = rom_q1;
  assign if0.sample_ready = ready;
  assign if1.sample_ready = ready;

  always @(posedge clk) begin
    if (if0.rom_rd) rom_q0 <= rom_mem[if0.rom_addr];
    if (if1.rom_rd) rom_q1 <= rom_mem[if1.rom_addr];
  end

  dds_phase_gen #(.SIGNED_OUT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .ftw(ftw),
    .phase_off(phase_off), .div(div), .bus(if0),
    .wrap(wrap0), .overrun(overrun0), .overrun_flag(oflag0)
  );

  dds_phase_gen #(.SIGNED_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .ftw(ftw),
    .phase_off(phase_off), .div(div), .bus(if1),
    .wrap(wrap1), .overrun(overrun1), .overrun_flag(oflag1)
  );

  typedef struct packed {
    logic [23:0]     ftw;
    logic [7:0]      off;
    logic [15:0]     div;
    logic [3:0][7:0] addr;   // first four read addresses, index 0 first
    logic [3:0]      wrap;   // wrap seen with each of those reads
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clear with new settings, then run until the first four reads and samples are seen.
  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] ra [4];
    logic       rw [4];
    logic [7:0] s0 [4];
    logic [7:0] s1 [4];
    int         rc [4];
    int         sc [4];
    int         nr = 0;
    int         ns = 0;
    @(negedge clk);
    en = 1'b0; sync_clr = 1'b1; ftw = v.ftw; phase_off = v.off; div = v.div; ready = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; en = 1'b1;
    for (int c = 0; c < 60 && (nr < 4 || ns < 4); c++) begin
      @(negedge clk);
      if (if0.rom_rd && nr < 4) begin
        ra[nr] = if0.rom_addr; rw[nr] = wrap0; rc[nr] = cyc; nr++;
      end
      if (if0.sample_valid && ns < 4) begin
        s0[ns] = if0.sample_out; s1[ns] = if1.sample_out; sc[ns] = cyc; ns++;
      end
    end
    check($sformatf("v%0d_reads_seen", idx), 32'(nr), 32'd4);
    check($sformatf("v%0d_samples_seen", idx), 32'(ns), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < nr) begin
        check($sformatf("v%0d_addr%0d", idx, k), 32'(ra[k]), 32'(v.addr[k]));
        check($sformatf("v%0d_wrap%0d", idx, k), 32'(rw[k]), 32'(v.wrap[k]));
        if (k > 0)
          check($sformatf("v%0d_period%0d", idx, k), 32'(rc[k] - rc[k-1]), 32'(v.div) + 32'd1);
      end
      if (k < ns) begin
        check($sformatf("v%0d_sample%0d", idx, k), 32'(s0[k]), 32'(rom_mem[v.addr[k]]));
        check($sformatf("v%0d_signed%0d", idx, k), 32'(s1[k]), 32'(rom_mem[v.addr[k]] ^ 8'h80));
      end
      if (k < nr && k < ns)
        check($sformatf("v%0d_latency%0d", idx, k), 32'(sc[k] - rc[k]), 32'd2);
    end
    en = 1'b0;
  endtask

  // First read and first sample after a restart; both must come from the new phase.
  task automatic first_after(input string tag, input logic [7:0] exp_addr);
    int rc = -1;
    int sc = -1;
    logic [7:0] a = '0;
    logic [7:0] s0 = '0;
    logic [7:0] s1 = '0;
    for (int c = 0; c < 20 && (rc < 0 || sc < 0); c++) begin
      @(negedge clk);
      if (if0.rom_rd && rc < 0) begin a = if0.rom_addr; rc = cyc; end
      if (if0.sample_valid && sc < 0) begin s0 = if0.sample_out; s1 = if1.sample_out; sc = cyc; end
    end
    check({tag, "_restart_seen"}, 32'((rc >= 0) && (sc >= 0)), 32'd1);
    check({tag, "_first_addr"}, 32'(a), 32'(exp_addr));
    check({tag, "_first_sample"}, 32'(s0), 32'(rom_mem[exp_addr]));
    check({tag, "_first_signed"}, 32'(s1), 32'(rom_mem[exp_addr] ^ 8'h80));
    check({tag, "_no_stale"}, 32'(sc - rc), 32'd2);
  endtask

  initial begin
    int n_ovr;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i * 37 + 11);

    vecs[0] = '{24'h010000, 8'h00, 16'd0, {8'h03, 8'h02, 8'h01, 8'h00}, 4'b0000};
    vecs[1] = '{24'hFF0000, 8'h00, 16'd0, {8'hFD, 8'hFE, 8'hFF, 8'h00}, 4'b1110};
    vecs[2] = '{24'h020000, 8'h00, 16'd3, {8'h06, 8'h04, 8'h02, 8'h00}, 4'b0000};
    vecs[3] = '{24'h000000, 8'h40, 16'd0, {8'h40, 8'h40, 8'h40, 8'h40}, 4'b0000};
    vecs[4] = '{24'h800000, 8'h10, 16'd1, {8'h90, 8'h10, 8'h90, 8'h10}, 4'b1010};
    vecs[5] = '{24'hFFFFFF, 8'hF0, 16'd2, {8'hEF, 8'hEF, 8'hEF, 8'hF0}, 4'b1110};

    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; ftw = '0; phase_off = '0; div = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rom_rd", 32'(if0.rom_rd), 32'd0);
    check("rst_rom_addr", 32'(if0.rom_addr), 32'd0);
    check("rst_valid", 32'(if0.sample_valid), 32'd0);
    check("rst_sample", 32'(if0.sample_out), 32'd0);
    check("rst_wrap", 32'(wrap0), 32'd0);
    check("rst_overrun", 32'(overrun0), 32'd0);
    check("rst_oflag", 32'(oflag0), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Overrun: five ticks into a stalled consumer, then drain.
    @(negedge clk);
    sync_clr = 1'b1; en = 1'b0; ftw = 24'h010000; phase_off = 8'h00; div = 16'd0; ready = 1'b0;
    @(negedge clk);
    sync_clr = 1'b0; en = 1'b1;
    n_ovr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (overrun0) n_ovr++;
      if (c == 4) en = 1'b0;
    end
    check("ovr_pulses", 32'(n_ovr), 32'd3);
    check("ovr_flag", 32'(oflag0), 32'd1);
    check("ovr_flag_signed", 32'(oflag1), 32'd1);
    check("ovr_pulse_gone", 32'(overrun0), 32'd0);
    check("ovr_hold_valid", 32'(if0.sample_valid), 32'd1);
    check("ovr_hold_head", 32'(if0.sample_out), 32'(rom_mem[0]));
    check("ovr_hold_signed", 32'(if1.sample_out), 32'(rom_mem[0] ^ 8'h80));
    ready = 1'b1;
    @(negedge clk);
    check("ovr_second_valid", 32'(if0.sample_valid), 32'd1);
    check("ovr_second_head", 32'(if0.sample_out), 32'(rom_mem[1]));
    @(negedge clk);
    check("ovr_drained", 32'(if0.sample_valid), 32'd0);
    check("ovr_en0_no_rd", 32'(if0.rom_rd), 32'd0);
    check("ovr_flag_sticky", 32'(oflag0), 32'd1);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    check("ovr_flag_cleared", 32'(oflag0), 32'd0);

    // sync_clr in the middle of a running stream.
    ftw = 24'h010000; phase_off = 8'h20; div = 16'd0; ready = 1'b1; en = 1'b1;
    repeat (6) @(negedge clk);
    check("clr_pre_valid", 32'(if0.sample_valid), 32'd1);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    check("clr_valid", 32'(if0.sample_valid), 32'd0);
    check("clr_rom_rd", 32'(if0.rom_rd), 32'd0);
    first_after("clr", 8'h20);

    // Asynchronous reset in the middle of a running stream.
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if0.sample_valid), 32'd0);
    check("arst_rom_rd", 32'(if0.rom_rd), 32'd0);
    check("arst_sample", 32'(if0.sample_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    first_after("arst", 8'h20);

    en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
